axi_burst_mem_sched: RTL and testbench

AXI_BURST_MEM_SCHED -- requirements
Module: axi_burst_mem_sched

---
 rtl/axi_burst_mem_sched.sv | 128 ++++++++++++
 tb/tb_axi_burst_mem_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem_sched.sv
// Schedules AXI-style write/read burst commands onto a single-port 32-bit word memory.
// Round-robin arbitration in IDLE, then one beat per handshake with FIXED/INCR/WRAP addressing.
module axi_burst_mem_sched #(
  parameter int MEM_AW = 8,
  parameter int ADDR_W = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              wcmd_valid,
  output logic              wcmd_ready,
  input  logic [ADDR_W-1:0] wcmd_addr,
  input  logic [7:0]        wcmd_len,
  input  logic [1:0]        wcmd_burst,
  input  logic              rcmd_valid,
  output logic              rcmd_ready,
  input  logic [ADDR_W-1:0] rcmd_addr,
  input  logic [7:0]        rcmd_len,
  input  logic [1:0]        rcmd_burst,
  input  logic              wbeat_valid,
  output logic              wbeat_ready,
  input  logic              rbeat_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              beat_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a command transfers in the cycle cmd_valid && cmd_ready; a write beat in
  // the cycle wbeat_valid && wbeat_ready; a read beat in any RD cycle with rbeat_ready high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_rd;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [1:0]        r_burst;

  logic              w_grant_w;
  logic              w_grant_r;
  logic              w_fire;
  logic              w_last;
  logic              w_wrap;
  logic [MEM_AW-1:0] w_mask;
  logic [MEM_AW-1:0] w_inc;
  logic [MEM_AW-1:0] w_addr_adv;
  logic              w_unused;

  assign w_unused = ^{wcmd_addr, rcmd_addr};

  // Ready is gated by reset so nothing is granted while ARESETN is held low.
  assign w_grant_w = (r_state == IDLE) && S_AXI_ARESETN && wcmd_valid &&
                     (!rcmd_valid || r_last_rd);
  assign w_grant_r = (r_state == IDLE) && S_AXI_ARESETN && rcmd_valid && !w_grant_w;

  assign w_fire = ((r_state == WR) && wbeat_valid) || ((r_state == RD) && rbeat_ready);
  assign w_last = w_fire && (r_cnt == r_len);

  // WRAP only keeps the low log2(len+1) address bits rolling; other lengths fall back to INCR.
  assign w_wrap = (r_burst == 2'b10) &&
                  ((r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15));
  assign w_mask = w_wrap ? MEM_AW'(r_len[3:0]) : '0;
  assign w_inc  = r_addr + MEM_AW'(1);
  assign w_addr_adv = (r_burst == 2'b00) ? r_addr :
                      w_wrap ? ((r_addr & ~w_mask) | (w_inc & w_mask)) : w_inc;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_w)      w_state_nxt = WR;
        else if (w_grant_r) w_state_nxt = RD;
      end
      WR, RD: begin
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_last_rd <= 1'b1;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
    end else if (w_grant_w) begin
      r_last_rd <= 1'b0;
      r_addr    <= wcmd_addr[MEM_AW+1:2];
      r_len     <= wcmd_len;
      r_burst   <= wcmd_burst;
      r_cnt     <= '0;
    end else if (w_grant_r) begin
      r_last_rd <= 1'b1;
      r_addr    <= rcmd_addr[MEM_AW+1:2];
      r_len     <= rcmd_len;
      r_burst   <= rcmd_burst;
      r_cnt     <= '0;
    end else if (w_fire) begin
      r_addr <= w_addr_adv;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign wcmd_ready  = w_grant_w;
  assign rcmd_ready  = w_grant_r;
  assign mem_en      = w_fire;
  assign mem_we      = w_fire && (r_state == WR);
  assign wbeat_ready = w_fire && (r_state == WR);
  assign mem_addr    = r_addr;
  assign beat_last   = w_last;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_axi_burst_mem_sched.sv
// Randomized bench for axi_burst_mem_sched: directed bursts, round-robin grants, mid-burst reset,
// and random commands scored against an arithmetic address/arbitration model.
module tb_axi_burst_mem_sched;

  localparam int MEM_AW = 8;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wcmd_valid = 1'b0;
  logic              wcmd_ready;
  logic [ADDR_W-1:0] wcmd_addr = '0;
  logic [7:0]        wcmd_len = '0;
  logic [1:0]        wcmd_burst = '0;
  logic              rcmd_valid = 1'b0;
  logic              rcmd_ready;
  logic [ADDR_W-1:0] rcmd_addr = '0;
  logic [7:0]        rcmd_len = '0;
  logic [1:0]        rcmd_burst = '0;
  logic              wbeat_valid = 1'b0;
  logic              wbeat_ready;
  logic              rbeat_ready = 1'b0;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic              beat_last;
  logic              busy;
  logic [1:0]        dbg_state;

  axi_burst_mem_sched #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .wcmd_valid   (wcmd_valid),
    .wcmd_ready   (wcmd_ready),
    .wcmd_addr    (wcmd_addr),
    .wcmd_len     (wcmd_len),
    .wcmd_burst   (wcmd_burst),
    .rcmd_valid   (rcmd_valid),
    .rcmd_ready   (rcmd_ready),
    .rcmd_addr    (rcmd_addr),
    .rcmd_len     (rcmd_len),
    .rcmd_burst   (rcmd_burst),
    .wbeat_valid  (wbeat_valid),
    .wbeat_ready  (wbeat_ready),
    .rbeat_ready  (rbeat_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .beat_last    (beat_last),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int               n_checks = 0;
  int               n_pass = 0;
  logic [7:0]       exp_q[$];
  bit               model_last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference address of beat i, from the burst rules in plain arithmetic.
  function automatic logic [7:0] beat_addr(input logic [7:0] start, input int len,
                                           input logic [1:0] burst, input int i);
    int n;
    int s;
    n = len + 1;
    s = int'(start);
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
      return 8'((s - (s % n)) + ((s % n) + i) % n);
    return 8'((s + i) % 256);
  endfunction

  function automatic logic [14:0] obs();
    return {busy, wcmd_ready, rcmd_ready, mem_en, mem_we, wbeat_ready, beat_last, mem_addr};
  endfunction

  function automatic logic [7:0] rand_len();
    case ($urandom_range(0, 5))
      0:       return 8'd1;
      1:       return 8'd3;
      2:       return 8'd7;
      3:       return 8'd15;
      default: return 8'($urandom_range(0, 20));
    endcase
  endfunction

  // Driver: offer commands in an IDLE cycle, check the grant, then drive and score every beat.
  // mode 0: handshake always high, 1: toggles 1,0,1,0..., 2: random. abort_after >= 0 resets
  // the DUT once that many beats have fired.
  task automatic run_cmd(input bit wv, input bit rv,
                         input logic [31:0] wa, input logic [7:0] wl, input logic [1:0] wb,
                         input logic [31:0] ra, input logic [7:0] rl, input logic [1:0] rb,
                         input int mode, input int abort_after);
    bit          win_w;
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    logic [14:0] o;
    logic [7:0]  cur;
    bit          h;
    int          i;
    int          cyc;
    win_w = wv && (!rv || model_last_rd);
    wcmd_valid = wv; wcmd_addr = wa; wcmd_len = wl; wcmd_burst = wb;
    rcmd_valid = rv; rcmd_addr = ra; rcmd_len = rl; rcmd_burst = rb;
    @(negedge clk);
    o = obs();
    check("grant", 32'(o[14:8]), 32'({1'b0, win_w, !win_w, 4'b0000}));
    if (!(wcmd_ready || rcmd_ready)) begin
      wcmd_valid = 1'b0;
      rcmd_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    model_last_rd = !win_w;
    a = win_w ? wa : ra;
    l = win_w ? wl : rl;
    b = win_w ? wb : rb;
    for (int k = 0; k <= int'(l); k++) exp_q.push_back(beat_addr(a[MEM_AW+1:2], int'(l), b, k));
    @(posedge clk); #1;
    if (win_w) wcmd_valid = 1'b0;
    else       rcmd_valid = 1'b0;
    i = 0;
    cyc = 0;
    while (i <= int'(l) && cyc < 4 * (int'(l) + 1) + 8) begin
      if (i == abort_after) begin
        wcmd_valid = 1'b0;
        rcmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        o = obs();
        check("abort_outputs", 32'(o), 32'd0);
        exp_q.delete();
        return;
      end
      h = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (win_w) begin
        wbeat_valid = h;
        rbeat_ready = 1'($urandom_range(0, 1));
      end else begin
        rbeat_ready = h;
        wbeat_valid = 1'($urandom_range(0, 1));
      end
      cur = exp_q[0];
      @(negedge clk);
      o = obs();
      check(win_w ? "wr_beat" : "rd_beat", 32'(o),
            32'({1'b1, 2'b00, h, h & win_w, h & win_w, (h && (i == int'(l))), cur}));
      if (h) begin
        void'(exp_q.pop_front());
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (i <= int'(l)) check("beat_timeout", 32'(i), 32'(int'(l) + 1));
    exp_q.delete();
    wbeat_valid = 1'b1;
    rbeat_ready = 1'b1;
  endtask

  initial begin
    logic [14:0] o;
    bit          wv;
    bit          rv;

    // Reset with every request input active: all outputs must stay low.
    wcmd_valid = 1'b1; rcmd_valid = 1'b1; wbeat_valid = 1'b1; rbeat_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = obs();
    check("reset_outputs", 32'(o), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last_rd = 1'b1;

    // Simultaneous offers from reset: W,R,W,R with one IDLE cycle between bursts.
    repeat (4) run_cmd(1'b1, 1'b1, 32'h0000_0020, 8'd1, 2'b01, 32'h0000_0080, 8'd2, 2'b01, 0, -1);

    // Directed bursts.
    run_cmd(1'b1, 1'b0, 32'h0, 8'd15, 2'b01, 32'h0, 8'd0, 2'b00, 0, -1);
    run_cmd(1'b0, 1'b1, 32'h0, 8'd0, 2'b00, 32'h18, 8'd7, 2'b10, 0, -1);
    run_cmd(1'b1, 1'b0, 32'(254 * 4), 8'd3, 2'b01, 32'h0, 8'd0, 2'b00, 0, -1);
    run_cmd(1'b0, 1'b1, 32'h0, 8'd0, 2'b00, 32'h40, 8'd3, 2'b00, 0, -1);
    run_cmd(1'b1, 1'b0, 32'h0000_0103, 8'd3, 2'b01, 32'h0, 8'd0, 2'b00, 1, -1);
    run_cmd(1'b0, 1'b1, 32'h0, 8'd0, 2'b00, 32'hFFFF_FF7E, 8'd0, 2'b01, 0, -1);
    run_cmd(1'b1, 1'b0, 32'h0000_0034, 8'd5, 2'b10, 32'h0, 8'd0, 2'b00, 2, -1);
    run_cmd(1'b0, 1'b1, 32'h0, 8'd0, 2'b00, 32'h0000_03F4, 8'd4, 2'b11, 0, -1);
    run_cmd(1'b1, 1'b0, 32'h0000_03E8, 8'd15, 2'b10, 32'h0, 8'd0, 2'b00, 2, -1);

    // Reset after two beats of a 16-beat write; nothing may fire after release.
    run_cmd(1'b1, 1'b0, 32'h0, 8'd15, 2'b01, 32'h0, 8'd0, 2'b00, 0, 2);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last_rd = 1'b1;
    wbeat_valid = 1'b1;
    rbeat_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      o = obs();
      check("post_reset_idle", 32'(o[14:8]), 32'd0);
      @(posedge clk); #1;
    end
    run_cmd(1'b1, 1'b1, 32'h0000_0010, 8'd2, 2'b01, 32'h0000_0050, 8'd1, 2'b01, 0, -1);

    // Random commands with random beat gaps.
    repeat (40) begin
      wv = 1'($urandom_range(0, 1));
      rv = wv ? 1'($urandom_range(0, 1)) : 1'b1;
      run_cmd(wv, rv, $urandom, rand_len(), 2'($urandom_range(0, 3)),
              $urandom, rand_len(), 2'($urandom_range(0, 3)), 2, -1);
    end

    wcmd_valid = 1'b0;
    rcmd_valid = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
